// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: bit-serial pattern generator with repeat/gap control.
// Shifts a WIDTH-bit pattern out MSB-first on x with a valid strobe,
// optionally repeating it with idle gaps, then pulses done.
module seq_pattern_tx #(
  parameter int                 WIDTH   = 4,
  parameter logic [WIDTH-1:0]   PATTERN = 4'b1101,
  parameter int                 GAP     = 1,
  parameter int                 RPT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             use_custom,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic [RPT_W-1:0] repeats,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
  localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    GAP_WAIT = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] pat, pat_n;      // latched pattern, reloaded per repetition
  logic [WIDTH-1:0] sh, sh_n;        // bits still to be sent, MSB next
  logic [BCW-1:0]   bitcnt, bit_n;   // index of the bit currently on x
  logic [GCW-1:0]   gapcnt, gap_n;
  logic [RPT_W-1:0] rcnt, rcnt_n;    // completed repetitions
  logic [RPT_W-1:0] rlat, rlat_n;    // latched repeat count, never 0
  logic             x_n, xv_n, busy_n, done_n;
  logic [WIDTH-1:0] sel;
  logic             last_rep;

  assign sel      = use_custom ? pattern_in : PATTERN;
  assign last_rep = (rcnt == (rlat - RPT_W'(1)));

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pat     <= PATTERN;
      sh      <= PATTERN;
      bitcnt  <= '0;
      gapcnt  <= '0;
      rcnt    <= '0;
      rlat    <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      pat     <= pat_n;
      sh      <= sh_n;
      bitcnt  <= bit_n;
      gapcnt  <= gap_n;
      rcnt    <= rcnt_n;
      rlat    <= rlat_n;
      x       <= x_n;
      x_valid <= xv_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  // Next-state and next-output logic; x only set together with x_valid
  always_comb begin
    state_n = state;
    pat_n   = pat;
    sh_n    = sh;
    bit_n   = bitcnt;
    gap_n   = gapcnt;
    rcnt_n  = rcnt;
    rlat_n  = rlat;
    x_n     = 1'b0;
    xv_n    = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          pat_n   = sel;
          sh_n    = sel << 1;
          bit_n   = '0;
          rcnt_n  = '0;
          rlat_n  = (repeats == '0) ? RPT_W'(1) : repeats;
          x_n     = sel[WIDTH-1];
          xv_n    = 1'b1;
          busy_n  = 1'b1;
          state_n = SEND;
        end
      end
      SEND: begin
        busy_n = 1'b1;
        if (bitcnt != BIT_LAST) begin
          x_n   = sh[WIDTH-1];
          xv_n  = 1'b1;
          sh_n  = sh << 1;
          bit_n = bitcnt + BCW'(1);
        end else if (!last_rep) begin
          rcnt_n = rcnt + RPT_W'(1);
          if (GAP > 0) begin
            gap_n   = '0;
            state_n = GAP_WAIT;
          end else begin
            // zero gap: MSB of the next repetition follows the LSB directly
            x_n   = pat[WIDTH-1];
            xv_n  = 1'b1;
            sh_n  = pat << 1;
            bit_n = '0;
          end
        end else begin
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = DONE;
        end
      end
      GAP_WAIT: begin
        busy_n = 1'b1;
        if (gapcnt == GAP_LAST) begin
          x_n     = pat[WIDTH-1];
          xv_n    = 1'b1;
          sh_n    = pat << 1;
          bit_n   = '0;
          state_n = SEND;
        end else begin
          gap_n = gapcnt + GCW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        pat_n   = PATTERN;
        sh_n    = PATTERN;
        bit_n   = '0;
        gap_n   = '0;
        rcnt_n  = '0;
        rlat_n  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: one instance with GAP=1, one with GAP=0.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       use_custom;
  logic [3:0] pattern_in;
  logic [3:0] repeats;
  logic       x, x_valid, busy, done;
  logic       x0, xv0, busy0, done0;

  int nvec = 0;
  int nerr = 0;
  logic [3:0] pat_d = 4'b1101;

  always #5 clk = ~clk;

  seq_pattern_tx #(.WIDTH(4), .PATTERN(4'b1101), .GAP(1), .RPT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .use_custom(use_custom),
    .pattern_in(pattern_in), .repeats(repeats),
    .x(x), .x_valid(x_valid), .busy(busy), .done(done)
  );

  seq_pattern_tx #(.WIDTH(4), .PATTERN(4'b1101), .GAP(0), .RPT_W(4)) dut0 (
    .clk(clk), .reset(reset), .start(start), .use_custom(use_custom),
    .pattern_in(pattern_in), .repeats(repeats),
    .x(x0), .x_valid(xv0), .busy(busy0), .done(done0)
  );

  // advance one cycle; inputs driven and outputs sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    logic [3:0] got;
    reset = 1'b1; start = 1'b1; use_custom = 1'b0; pattern_in = 4'h0; repeats = 4'd1;
    tick(); tick();
    got = {x, x_valid, busy, done};
    nvec++;
    if (got !== 4'b0000) begin
      nerr++; $display("FAIL reset_gap1: x/xv/busy/done=%b expected %b", got, 4'b0000);
    end
    got = {x0, xv0, busy0, done0};
    nvec++;
    if (got !== 4'b0000) begin
      nerr++; $display("FAIL reset_gap0: x/xv/busy/done=%b expected %b", got, 4'b0000);
    end
    start = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_default();
    logic [3:0] got, exp;
    use_custom = 1'b0; repeats = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c <= 4)      exp = {pat_d[4-c], 3'b110};
      else if (c == 5) exp = 4'b0001;
      else             exp = 4'b0000;
      got = {x, x_valid, busy, done};
      nvec++;
      if (got !== exp) begin
        nerr++; $display("FAIL default cycle %0d: x/xv/busy/done=%b expected %b", c, got, exp);
      end
      tick();
    end
    settle(3);
  endtask

  task automatic test_custom();
    logic [3:0] got, exp, cp;
    cp = 4'b0110;
    use_custom = 1'b1; pattern_in = cp; repeats = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (c <= 4)      exp = {cp[4-c], 3'b110};
      else if (c == 5) exp = 4'b0001;
      else             exp = 4'b0000;
      got = {x, x_valid, busy, done};
      nvec++;
      if (got !== exp) begin
        nerr++; $display("FAIL custom cycle %0d: x/xv/busy/done=%b expected %b", c, got, exp);
      end
      tick();
    end
    use_custom = 1'b0;
    settle(3);
  endtask

  task automatic test_repeat_gap();
    logic [3:0] got, exp;
    use_custom = 1'b0; repeats = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (c <= 4)       exp = {pat_d[4-c], 3'b110};
      else if (c == 5)  exp = 4'b0010;
      else if (c <= 9)  exp = {pat_d[9-c], 3'b110};
      else if (c == 10) exp = 4'b0001;
      else              exp = 4'b0000;
      got = {x, x_valid, busy, done};
      nvec++;
      if (got !== exp) begin
        nerr++; $display("FAIL repeat_gap cycle %0d: x/xv/busy/done=%b expected %b", c, got, exp);
      end
      tick();
    end
    settle(3);
  endtask

  task automatic test_back_to_back();
    logic [3:0] got, exp;
    int busy_cnt;
    busy_cnt = 0;
    use_custom = 1'b0; repeats = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      if (c <= 14) begin
        if (c <= 12)      exp = {pat_d[3 - ((c - 1) % 4)], 3'b110};
        else if (c == 13) exp = 4'b0001;
        else              exp = 4'b0000;
        got = {x0, xv0, busy0, done0};
        nvec++;
        if (got !== exp) begin
          nerr++; $display("FAIL back_to_back cycle %0d: x/xv/busy/done=%b expected %b", c, got, exp);
        end
      end
      if (busy) busy_cnt++;
      tick();
    end
    // GAP=1 instance: 3*4 + 2*1 busy cycles
    nvec++;
    if (busy_cnt !== 14) begin
      nerr++; $display("FAIL busy_count_gap1: got %0d expected %0d", busy_cnt, 14);
    end
    settle(2);
  endtask

  task automatic test_start_while_busy();
    logic [3:0] got, exp;
    int ndone;
    ndone = 0;
    use_custom = 1'b0; pattern_in = 4'b0110; repeats = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c == 2) begin
        start = 1'b1; use_custom = 1'b1; pattern_in = 4'b0000; repeats = 4'd5;
      end else begin
        start = 1'b0;
      end
      if (c <= 4)      exp = {pat_d[4-c], 3'b110};
      else if (c == 5) exp = 4'b0001;
      else             exp = 4'b0000;
      got = {x, x_valid, busy, done};
      if (done) ndone++;
      nvec++;
      if (got !== exp) begin
        nerr++; $display("FAIL start_while_busy cycle %0d: x/xv/busy/done=%b expected %b", c, got, exp);
      end
      tick();
    end
    nvec++;
    if (ndone !== 1) begin
      nerr++; $display("FAIL start_while_busy_done_count: got %0d expected %0d", ndone, 1);
    end
    use_custom = 1'b0; repeats = 4'd1;
    settle(2);
  endtask

  task automatic test_reset_mid();
    logic [3:0] got, exp;
    int ndone;
    ndone = 0;
    use_custom = 1'b0; repeats = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    // cycle 3: third bit still visible, reset applied at the next edge
    got = {x, x_valid, busy, done};
    nvec++;
    if (got !== 4'b0110) begin
      nerr++; $display("FAIL reset_mid_pre: x/xv/busy/done=%b expected %b", got, 4'b0110);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      got = {x, x_valid, busy, done};
      if (done) ndone++;
      nvec++;
      if (got !== 4'b0000) begin
        nerr++; $display("FAIL reset_mid_after %0d: x/xv/busy/done=%b expected %b", c, got, 4'b0000);
      end
      tick();
    end
    nvec++;
    if (ndone !== 0) begin
      nerr++; $display("FAIL reset_mid_done_count: got %0d expected %0d", ndone, 0);
    end
    repeats = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      exp = (c <= 4) ? {pat_d[4-c], 3'b110} : 4'b0001;
      got = {x, x_valid, busy, done};
      nvec++;
      if (got !== exp) begin
        nerr++; $display("FAIL reset_mid_restart cycle %0d: x/xv/busy/done=%b expected %b", c, got, exp);
      end
      tick();
    end
    settle(3);
  endtask

  task automatic test_retrigger();
    logic [3:0] got, exp;
    use_custom = 1'b0; repeats = 4'd1; start = 1'b1;
    tick();
    for (int c = 1; c <= 12; c++) begin
      if (c >= 7) start = 1'b0;
      if (c <= 4)       exp = {pat_d[4-c], 3'b110};
      else if (c == 5)  exp = 4'b0001;
      else if (c == 6)  exp = 4'b0000;
      else if (c <= 10) exp = {pat_d[10-c], 3'b110};
      else if (c == 11) exp = 4'b0001;
      else              exp = 4'b0000;
      got = {x, x_valid, busy, done};
      nvec++;
      if (got !== exp) begin
        nerr++; $display("FAIL retrigger cycle %0d: x/xv/busy/done=%b expected %b", c, got, exp);
      end
      tick();
    end
    settle(2);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; use_custom = 1'b0; pattern_in = 4'h0; repeats = 4'd1;
    #1;
    test_reset();
    test_default();
    test_custom();
    test_repeat_gap();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid();
    test_retrigger();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
